// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types, sizes and the round-robin search helper used
//               by the 8-way arbiter and its grant decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Rotate-and-find-first: returns {found, index} of the first set request
  // at or above ptr, searching upward and wrapping from N_REQ-1 back to 0.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [IDX_W:0] find_first_rr(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = ptr + IDX_W'(i);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec3x8.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec3x8
// Description : 3-bit index to 8-bit one-hot decoder with enable; output is
//               all-zero when the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec3x8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  // Single-bit decode, gated by the enable.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-requester round-robin arbiter with a bounded hold time.
//               A grant lasts until done, until the grantee drops its request,
//               or until MAX_HOLD cycles elapse (timeout pulse). Every release
//               is followed by at least one idle turnaround cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W:0]   w_search;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_max;

  assign w_search = find_first_rr(req, ptr_q);
  assign w_found  = w_search[IDX_W];
  assign w_sel    = w_search[IDX_W-1:0];

  assign w_rel_done = done;
  assign w_rel_drop = ~req[idx_q];
  assign w_rel_max  = (cnt_q == C_HOLD_LAST);

  // Next-state logic: arbitrate in IDLE, count and watch release in GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && w_found) begin
          state_d = GRANT;
          idx_d   = w_sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_max) begin
          state_d   = IDLE;
          idx_d     = '0;
          cnt_d     = '0;
          ptr_d     = idx_q + 1'b1;
          // Flag only releases forced by the hold limit alone.
          timeout_d = w_rel_max && !w_rel_done && !w_rel_drop;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;

  onehot_dec3x8 u_dec (
    .idx_i    (idx_q),
    .en_i     (gnt_valid),
    .onehot_o (gnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Directed scoreboard bench for rr_arbiter8 (MAX_HOLD = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct {
    string       tag;
    logic [12:0] val;   // {gnt, gnt_idx, gnt_valid, timeout}
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic logic [12:0] pack_exp(input logic [7:0] g, input logic to);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) idx = 3'(i);
    end
    return {g, idx, |g, to};
  endfunction

  task automatic push(input string tag, input logic [7:0] g, input logic to);
    exp_t e;
    e.tag = tag;
    e.val = pack_exp(g, to);
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t        e;
    logic [12:0] obs;
    e   = sb.pop_front();
    obs = {gnt, gnt_idx, gnt_valid, timeout};
    total_cnt++;
    assert (obs === e.val) pass_cnt++;
    else $error("FAIL %s: observed gnt=%h idx=%0d valid=%b to=%b, required gnt=%h idx=%0d valid=%b to=%b",
                e.tag, obs[12:5], obs[4:2], obs[1], obs[0],
                e.val[12:5], e.val[4:2], e.val[1], e.val[0]);
  endtask

  // Push the expected outputs for the coming edge, then check just after it.
  task automatic step(input string tag, input logic [7:0] g, input logic to);
    push(tag, g, to);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 8'h00, 1'b0);
    compare_head();
    rst_n = 1'b1;

    // Basic grant, done release, turnaround, wrap-around priority.
    req = 8'h81; en = 1'b1;
    step("first_gnt0", 8'h01, 1'b0);
    done = 1'b1;
    step("rel_done0", 8'h00, 1'b0);
    done = 1'b0;
    step("gnt7", 8'h80, 1'b0);
    done = 1'b1; req = 8'h00;
    step("rel7", 8'h00, 1'b0);
    done = 1'b0;

    // All requesting: strict rotation 0..7 then back to 0.
    req = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      step($sformatf("rr_gnt%0d", i), 8'h01 << (i % 8), 1'b0);
      done = 1'b1;
      step($sformatf("rr_idle%0d", i), 8'h00, 1'b0);
      done = 1'b0;
    end
    req = 8'h00;
    step("rr_quiet", 8'h00, 1'b0);

    // Hold limit: four grant cycles, timeout with the release, re-grant.
    req = 8'h04;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold%0d", i), 8'h04, 1'b0);
    end
    step("timeout", 8'h00, 1'b1);
    step("regrant2", 8'h04, 1'b0);
    done = 1'b1;
    step("rel2", 8'h00, 1'b0);
    done = 1'b0; req = 8'h00;

    // Enable gates only the IDLE->GRANT transition.
    en = 1'b0; req = 8'h10;
    step("en0_a", 8'h00, 1'b0);
    step("en0_b", 8'h00, 1'b0);
    en = 1'b1;
    step("en1_gnt4", 8'h10, 1'b0);
    en = 1'b0;
    step("en0_hold1", 8'h10, 1'b0);
    step("en0_hold2", 8'h10, 1'b0);
    done = 1'b1;
    step("en0_rel", 8'h00, 1'b0);
    done = 1'b0;
    step("en0_nogrant", 8'h00, 1'b0);
    en = 1'b1; req = 8'h00;
    step("en_idle", 8'h00, 1'b0);

    // Grantee drops its request while another waits.
    req = 8'h08;
    step("gnt3", 8'h08, 1'b0);
    req = 8'h28;
    step("gnt3_hold", 8'h08, 1'b0);
    req = 8'h20;
    step("drop3_rel", 8'h00, 1'b0);
    step("gnt5", 8'h20, 1'b0);
    done = 1'b1; req = 8'h00;
    step("rel5", 8'h00, 1'b0);
    done = 1'b0;

    // Asynchronous reset mid-grant, pointer returns to 0.
    req = 8'h40;
    step("gnt6", 8'h40, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", 8'h00, 1'b0);
    compare_head();
    #1;
    rst_n = 1'b1;
    req   = 8'h41;
    step("post_rst_gnt0", 8'h01, 1'b0);
    done = 1'b1; req = 8'h00;
    step("post_rst_rel", 8'h00, 1'b0);
    done = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum cycles one grant may be held before forced release (legal 2..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  arbitration enable; 0 blocks new grants, current grant unaffected.
REQ-005 req  input  8  request vector; bit i = requester i.
REQ-006 done  input  1  current grantee releases the resource this cycle.
REQ-007 gnt  output  8  one-hot grant vector, all-zero when no grant.
REQ-008 gnt_idx  output  3  binary index of current grantee; 0 when gnt_valid=0.
REQ-009 gnt_valid  output  1  high while any grant is held.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 Two states: IDLE (no grant) and GRANT (one requester holds the resource).
REQ-012 IDLE: if en=1 and req!=0, select the first set bit of req at or above ptr, searching upward with wrap 7->0; next state GRANT.
REQ-013 Grant latency: gnt, gnt_idx, gnt_valid register one cycle after the sampling edge in IDLE; all outputs are registered.
REQ-014 gnt SHALL always equal the one-hot decode of gnt_idx when gnt_valid=1; never more than one bit set.
REQ-015 GRANT: hold counter starts at 0 on entry, increments by 1 per cycle in GRANT.
REQ-016 Release conditions in GRANT, any one sufficient: done=1; req[gnt_idx]=0; counter = MAX_HOLD-1.
REQ-017 On release: next state IDLE, gnt/gnt_idx/gnt_valid clear next cycle, ptr <= gnt_idx+1 modulo 8 (7 wraps to 0).
REQ-018 timeout pulses with the release cycle's output update only when release is caused solely by the counter (done=0 and req[gnt_idx]=1).
REQ-019 Release always forces at least one IDLE cycle (gnt_valid=0) before the next grant: bus turnaround.
REQ-020 en=0 in GRANT: grant and counter continue unchanged; en only gates the IDLE->GRANT transition.
REQ-021 Requests from non-grantees during GRANT are ignored; they are re-evaluated in IDLE from the updated ptr.
REQ-022 Single requester re-requesting immediately after release is re-granted after the single IDLE cycle.
REQ-023 req=0 in IDLE: remain IDLE, ptr unchanged.

Reset
REQ-024 rst_n=0 asynchronously forces state IDLE, ptr=0, counter=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0.
REQ-025 Reset asserted during GRANT drops the grant immediately without timeout pulse; after rst_n rises, first arbitration uses ptr=0.

Structure
REQ-026 Shared package arb_pkg holds N_REQ=8, IDX_W=3, and the state enum {IDLE, GRANT}.
REQ-027 Index-to-one-hot conversion is one sub-module, onehot_dec3x8 (3-bit index + enable in, 8-bit one-hot out), enable tied to gnt_valid.
REQ-028 Priority search is combinational rotate-and-find-first from ptr; no other sub-modules.

Verification
REQ-029 Reset then req=8'h81, en=1: grant idx 0 (gnt=8'h01) one cycle later; done=1 -> one IDLE cycle -> gnt=8'h80.
REQ-030 req=8'hFF held, done pulsed each grant: grant order 0,1,2,...,7,0 with one IDLE cycle between each.
REQ-031 MAX_HOLD=4, req=8'h04 held, done=0: gnt=8'h04 for exactly 4 cycles, timeout=1 on the release cycle, IDLE 1 cycle, re-grant 8'h04.
REQ-032 en=0 with req=8'h10: no grant; en rises -> gnt=8'h10 next cycle; en dropped mid-grant -> grant persists until done.
REQ-033 Grantee 3 drops req[3] while req[5]=1: release next cycle, timeout=0, then gnt=8'h20 after IDLE cycle.
REQ-034 rst_n pulsed low mid-grant of idx 6: gnt=0 immediately (asynchronous), after release with req=8'h41 grant goes to idx 0.
